// File: rtl/truth_table_checker.sv
// Response-side checker: accepts applied input vectors, waits a settle interval, then
// compares the circuit output to a truth table. Optional feature macro: TTC_ORDER_CHECK_EN.
module truth_table_checker #(
  parameter int                   N_IN       = 4,
  parameter logic [(2**N_IN)-1:0] EXPECT     = 16'h0000,
  parameter logic [(2**N_IN)-1:0] DC_MASK    = 16'h0000,
  parameter int                   SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   vec_valid,
  input  logic [N_IN-1:0]        vec_in,
  output logic                   vec_ready,
  input  logic                   dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic                   first_err_valid,
  output logic [N_IN-1:0]        first_err_idx,
  output logic                   dup_seen,
  output logic [(2**N_IN)-1:0]   coverage
`ifdef TTC_ORDER_CHECK_EN
  ,
  output logic                   order_err
`endif
);

  localparam int ROWS = 2**N_IN;
  localparam logic [N_IN:0] ERR_MAX = '1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]      state_reg, state_next;
  logic [3:0]      settle_reg, settle_next;
  logic [N_IN-1:0] vec_reg, vec_next;
  logic [N_IN:0]   err_reg, err_next;
  logic            first_valid_reg, first_valid_next;
  logic [N_IN-1:0] first_idx_reg, first_idx_next;
  logic            dup_reg, dup_next;
  logic [ROWS-1:0] cov_reg, cov_next;
`ifdef TTC_ORDER_CHECK_EN
  logic            order_err_reg, order_err_next;
  logic [N_IN-1:0] order_idx_reg, order_idx_next;
`endif

  // One-hot decode of the latched vector selects the table row.
  logic [ROWS-1:0] row_sel;
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_sel[gi] = (vec_reg == N_IN'(gi));
    end
  endgenerate

  logic exp_bit, care_bit, out_match, mismatch;
  assign exp_bit  = |(row_sel & EXPECT);
  assign care_bit = ~|(row_sel & DC_MASK);

  // Written as if/else so an unknown dut_out falls through to "no match".
  always_comb begin
    out_match = 1'b0;
    if (dut_out == exp_bit) out_match = 1'b1;
  end
  assign mismatch = care_bit & ~out_match;

  always_comb begin
    state_next       = state_reg;
    settle_next      = settle_reg;
    vec_next         = vec_reg;
    err_next         = err_reg;
    first_valid_next = first_valid_reg;
    first_idx_next   = first_idx_reg;
    dup_next         = dup_reg;
    cov_next         = cov_reg;
`ifdef TTC_ORDER_CHECK_EN
    order_err_next   = order_err_reg;
    order_idx_next   = order_idx_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next       = ST_RUN;
          settle_next      = '0;
          vec_next         = '0;
          err_next         = '0;
          first_valid_next = 1'b0;
          first_idx_next   = '0;
          dup_next         = 1'b0;
          cov_next         = '0;
`ifdef TTC_ORDER_CHECK_EN
          order_err_next   = 1'b0;
          order_idx_next   = '0;
`endif
        end
      end
      ST_RUN: begin
        // A handshake takes precedence over a coincident stop.
        if (vec_valid) begin
          state_next  = ST_WAIT;
          vec_next    = vec_in;
          settle_next = 4'(SETTLE_CYC);
        end else if (stop) begin
          state_next = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (settle_reg <= 4'd1) state_next = ST_CHECK;
        else                    settle_next = settle_reg - 4'd1;
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_reg != ERR_MAX) err_next = err_reg + 1'b1;
          if (!first_valid_reg) begin
            first_valid_next = 1'b1;
            first_idx_next   = vec_reg;
          end
        end
        if (|(cov_reg & row_sel)) dup_next = 1'b1;
        cov_next = cov_reg | row_sel;
`ifdef TTC_ORDER_CHECK_EN
        if (vec_reg != order_idx_reg) order_err_next = 1'b1;
        order_idx_next = order_idx_reg + 1'b1;
`endif
        state_next = (&cov_next) ? ST_DONE : ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      settle_reg      <= '0;
      vec_reg         <= '0;
      err_reg         <= '0;
      first_valid_reg <= 1'b0;
      first_idx_reg   <= '0;
      dup_reg         <= 1'b0;
      cov_reg         <= '0;
`ifdef TTC_ORDER_CHECK_EN
      order_err_reg   <= 1'b0;
      order_idx_reg   <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      settle_reg      <= settle_next;
      vec_reg         <= vec_next;
      err_reg         <= err_next;
      first_valid_reg <= first_valid_next;
      first_idx_reg   <= first_idx_next;
      dup_reg         <= dup_next;
      cov_reg         <= cov_next;
`ifdef TTC_ORDER_CHECK_EN
      order_err_reg   <= order_err_next;
      order_idx_reg   <= order_idx_next;
`endif
    end
  end

  assign vec_ready       = (state_reg == ST_RUN);
  assign busy            = (state_reg == ST_RUN) || (state_reg == ST_WAIT) || (state_reg == ST_CHECK);
  assign done            = (state_reg == ST_DONE);
  assign err_count       = err_reg;
  assign first_err_valid = first_valid_reg;
  assign first_err_idx   = first_idx_reg;
  assign dup_seen        = dup_reg;
  assign coverage        = cov_reg;
`ifdef TTC_ORDER_CHECK_EN
  assign order_err = order_err_reg;
  assign pass      = done && (err_reg == '0) && (&cov_reg) && !order_err_reg;
`else
  assign pass      = done && (err_reg == '0) && (&cov_reg);
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomised self-checking bench for truth_table_checker; a set-based model predicts every
// output each cycle, and literal expectations pin the directed scenarios.
module tb_truth_table_checker;

  localparam int          N_IN    = 4;
  localparam logic [15:0] EXP_TBL = 16'hA5C3;
  localparam logic [15:0] DC_TBL  = 16'h0810;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, vec_valid = 1'b0, dut_out = 1'b0;
  logic [3:0] vec_in = '0;
  logic vec_ready, busy, done, pass, first_err_valid, dup_seen;
  logic [4:0] err_count;
  logic [3:0] first_err_idx;
  logic [15:0] coverage;
`ifdef TTC_ORDER_CHECK_EN
  logic order_err;
`endif

  truth_table_checker #(.N_IN(N_IN), .EXPECT(EXP_TBL), .DC_MASK(DC_TBL), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .vec_valid(vec_valid),
    .vec_in(vec_in), .vec_ready(vec_ready), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .dup_seen(dup_seen), .coverage(coverage)
`ifdef TTC_ORDER_CHECK_EN
    , .order_err(order_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: expected outputs held as plain variables.
  logic [15:0] exp_tbl = EXP_TBL;
  logic [15:0] dc_tbl  = DC_TBL;
  logic m_ready, m_busy, m_done, m_fv, m_dup, m_oerr;
  int m_err, m_next_idx;
  logic [15:0] m_cov;
  logic [3:0] m_fidx;
  logic cmp_en = 1'b0;
  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic m_pass();
    logic p;
    p = (m_err == 0) && (m_cov == 16'hFFFF);
`ifdef TTC_ORDER_CHECK_EN
    if (m_oerr) p = 1'b0;
`endif
    return p;
  endfunction

  task automatic m_clear();
    m_err = 0; m_cov = '0; m_fv = 1'b0; m_fidx = '0; m_dup = 1'b0; m_oerr = 1'b0; m_next_idx = 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("vec_ready", 32'(vec_ready), 32'(m_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("err_count", 32'(err_count), 32'(m_err));
      chk("coverage", 32'(coverage), 32'(m_cov));
      chk("first_err_valid", 32'(first_err_valid), 32'(m_fv));
      chk("first_err_idx", 32'(first_err_idx), 32'(m_fidx));
      chk("dup_seen", 32'(dup_seen), 32'(m_dup));
`ifdef TTC_ORDER_CHECK_EN
      chk("order_err", 32'(order_err), 32'(m_oerr));
`endif
      if (m_done) chk("pass", 32'(pass), 32'(m_pass()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_clear();
    m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!m_busy) begin
      m_clear();
      m_ready = 1'b1; m_busy = 1'b1; m_done = 1'b0;
    end
    $display("start: busy=%0b", m_busy);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    if (m_ready) begin
      m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b1;
    end
    $display("stop: done=%0b err=%0d cov=%04h", m_done, m_err, m_cov);
  endtask

  // Hand one vector over; dut_out holds the wrong value except in the sampling cycle.
  task automatic apply(input logic [3:0] v, input bit good, input int gap, input bit stop_with,
                       input bit noise);
    logic d;
    d = good ? exp_tbl[v] : ~exp_tbl[v];
    repeat (gap) tick();
    vec_valid = 1'b1; vec_in = v; dut_out = ~d; stop = stop_with;
    tick();
    vec_valid = 1'b0; stop = 1'b0; m_ready = 1'b0;
    if (noise) begin stop = 1'b1; start = 1'b1; end
    tick();
    stop = 1'b0; start = 1'b0; dut_out = d;
    tick();
    tick();
    if (!dc_tbl[v] && d != exp_tbl[v]) begin
      if (m_err < 31) m_err++;
      if (!m_fv) begin m_fv = 1'b1; m_fidx = v; end
    end
    if (m_cov[v]) m_dup = 1'b1;
    m_cov[v] = 1'b1;
    if (int'(v) != m_next_idx) m_oerr = 1'b1;
    m_next_idx = (m_next_idx + 1) % 16;
    if (m_cov == 16'hFFFF) begin m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b1; end
    else m_ready = 1'b1;
    dut_out = 1'($urandom);
    $display("vec %0d dut_out=%0b err=%0d cov=%04h", v, d, m_err, m_cov);
  endtask

  initial begin
    logic [3:0] perm [16];
    int mode, n, j;
    logic [3:0] t;
    m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_clear();
    tick();
    do_reset();
    cmp_en = 1'b1;

    // Ascending, all correct.
    do_start();
    for (int i = 0; i < 16; i++) apply(4'(i), 1'b1, 0, 1'b0, 1'b0);
    tick();
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_err", 32'(err_count), 32'd0);
    chk("t1_cov", 32'(coverage), 32'hFFFF);
    chk("t1_model_cov", 32'(m_cov), 32'hFFFF);

    // Wrong on 5 and 9.
    do_start();
    for (int i = 0; i < 16; i++) apply(4'(i), !(i == 5 || i == 9), 0, 1'b0, 1'b0);
    tick();
    chk("t2_err", 32'(err_count), 32'd2);
    chk("t2_fidx", 32'(first_err_idx), 32'd5);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_model_err", 32'(m_err), 32'd2);

    // Wrong only on don't-care rows 4 and 11.
    do_start();
    for (int i = 0; i < 16; i++) apply(4'(i), !(i == 4 || i == 11), 1, 1'b0, 1'b0);
    tick();
    chk("t3_err", 32'(err_count), 32'd0);
    chk("t3_pass", 32'(pass), 32'd1);

    // Partial run with a duplicate, then stop.
    do_start();
    for (int i = 0; i < 8; i++) apply(4'(i), 1'b1, 0, 1'b0, i == 2);
    apply(4'd3, 1'b1, 0, 1'b0, 1'b0);
    do_stop();
    chk("t4_dup", 32'(dup_seen), 32'd1);
    chk("t4_cov", 32'(coverage), 32'h00FF);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_pass", 32'(pass), 32'd0);

    // Reset during the settle wait of vector 6, then vec_valid without start.
    do_start();
    for (int i = 0; i < 6; i++) apply(4'(i), 1'b1, 0, 1'b0, 1'b0);
    vec_valid = 1'b1; vec_in = 4'd6;
    tick();
    vec_valid = 1'b0; m_ready = 1'b0;
    do_reset();
    chk("t5_cov", 32'(coverage), 32'd0);
    vec_valid = 1'b1; vec_in = 4'd2;
    repeat (6) tick();
    vec_valid = 1'b0;
    chk("t5_ready", 32'(vec_ready), 32'd0);
    chk("t5_err", 32'(err_count), 32'd0);

    // Saturation of err_count on a repeated care row, with a stop+handshake collision.
    do_start();
    do_start();
    for (int i = 0; i < 34; i++) apply(4'd5, 1'b0, 0, i == 3, 1'b0);
    do_stop();
    chk("sat_err", 32'(err_count), 32'd31);

`ifdef TTC_ORDER_CHECK_EN
    do_start();
    for (int i = 0; i < 16; i++) apply((i == 2) ? 4'd3 : (i == 3) ? 4'd2 : 4'(i), 1'b1, 0, 1'b0, 1'b0);
    tick();
    chk("ord_err", 32'(order_err), 32'd1);
    chk("ord_pass", 32'(pass), 32'd0);
    chk("ord_errcnt", 32'(err_count), 32'd0);
`endif

    // Randomised runs.
    for (int r = 0; r < 14; r++) begin
      do_start();
      mode = int'($urandom_range(0, 2));
      if (mode == 0) begin
        for (int i = 0; i < 16; i++) perm[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 16; i++)
          apply(perm[i], $urandom_range(0, 7) != 0, int'($urandom_range(0, 2)), 1'b0,
                $urandom_range(0, 3) == 0);
      end else begin
        n = (mode == 1) ? 20 : int'($urandom_range(1, 10));
        for (int i = 0; i < n && !m_done; i++)
          apply(4'($urandom), $urandom_range(0, 5) != 0, int'($urandom_range(0, 2)),
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
        if (!m_done) do_stop();
      end
      repeat (2) tick();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
